// File: rtl/count_event_tracker.sv
// count_event_tracker: watches a 4-bit up/down counter, checks every step,
// and queues timestamped OVF / UNF / STEP_ERR events on a valid/ready port.
// It also keeps saturating statistics for each event type and for dropped events.
module count_event_tracker #(
    parameter int FIFO_DEPTH = 4,
    parameter int STAMP_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               updo,
    input  logic [3:0]         count,
    input  logic               evt_ready,
    output logic               evt_valid,
    output logic [1:0]         evt_code,
    output logic [STAMP_W-1:0] evt_stamp,
    output logic [7:0]         ovf_cnt,
    output logic [7:0]         unf_cnt,
    output logic [7:0]         err_cnt,
    output logic [7:0]         drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] EV_OVF = 2'b00;
    localparam logic [1:0] EV_UNF = 2'b01;
    localparam logic [1:0] EV_ERR = 2'b10;

    typedef enum logic {S_INIT, S_TRACK} state_t;

    typedef struct packed {
        logic [1:0]         code;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    state_t               state_q, state_d;
    logic [3:0]           prev_count_q, prev_count_d;
    logic                 prev_updo_q, prev_updo_d;
    logic [STAMP_W-1:0]   stamp_q, stamp_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          occ_q, occ_d;
    entry_t               mem_q [FIFO_DEPTH];
    entry_t               mem_d [FIFO_DEPTH];
    logic [7:0]           ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;
    logic [7:0]           err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;

    logic [3:0] expected;
    logic       det;
    logic [1:0] det_code;
    logic       full, pop, push, drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && v != 8'hFF) ? v + 8'd1 : v;
    endfunction

    // Step checker: compare the sample against the predicted next value.
    always_comb begin
        expected = prev_updo_q ? prev_count_q + 4'd1 : prev_count_q - 4'd1;
        det      = 1'b0;
        det_code = EV_OVF;
        if (state_q == S_TRACK) begin
            if (count != expected) begin
                det      = 1'b1;
                det_code = EV_ERR;
            end else if (prev_updo_q && prev_count_q == 4'd15) begin
                det      = 1'b1;
                det_code = EV_OVF;
            end else if (!prev_updo_q && prev_count_q == 4'd0) begin
                det      = 1'b1;
                det_code = EV_UNF;
            end
        end
    end

    // Next-state: FSM, history reload, queue bookkeeping and statistics.
    always_comb begin
        state_d      = S_TRACK;
        prev_count_d = count;
        prev_updo_d  = updo;
        stamp_d      = stamp_q + 1'b1;

        // A full queue still accepts an event when its head leaves on the same edge.
        full = (occ_q == DEPTH_L);
        pop  = (occ_q != '0) && evt_ready;
        push = det && (!full || pop);
        drop = det && full && !pop;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{code: det_code, stamp: stamp_q};
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop)      occ_d = occ_q + 1'b1;
        else if (pop && !push) occ_d = occ_q - 1'b1;

        ovf_cnt_d  = sat_inc(ovf_cnt_q, det && det_code == EV_OVF);
        unf_cnt_d  = sat_inc(unf_cnt_q, det && det_code == EV_UNF);
        err_cnt_d  = sat_inc(err_cnt_q, det && det_code == EV_ERR);
        drop_cnt_d = sat_inc(drop_cnt_q, drop);
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_INIT;
            prev_count_q <= '0;
            prev_updo_q  <= 1'b0;
            stamp_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ovf_cnt_q    <= '0;
            unf_cnt_q    <= '0;
            err_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_updo_q  <= prev_updo_d;
            stamp_q      <= stamp_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            ovf_cnt_q    <= ovf_cnt_d;
            unf_cnt_q    <= unf_cnt_d;
            err_cnt_q    <= err_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Queue storage; contents are don't-care while occupancy is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head is masked to zero when nothing is queued.
    assign evt_valid = (occ_q != '0);
    assign evt_code  = evt_valid ? mem_q[rd_ptr_q].code  : '0;
    assign evt_stamp = evt_valid ? mem_q[rd_ptr_q].stamp : '0;
    assign ovf_cnt   = ovf_cnt_q;
    assign unf_cnt   = unf_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: doc/count_event_tracker.md
COUNT_EVENT_TRACKER -- requirements
Module: count_event_tracker

Purpose: downstream consumer of the 4-bit up/down counter; checks every step, timestamps wrap and error events, and queues them on a valid/ready port.

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning event queue entries (power of 2, at least 2).
REQ-002 Parameter STAMP_W, default 8, meaning timestamp width.
REQ-003 clk  input  1  meaning the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  meaning reset, synchronous, active-low.
REQ-005 updo  input  1  meaning the counter direction control: 1 counts up, 0 counts down.
REQ-006 count  input  4  meaning the counter output.
REQ-007 evt_ready  input  1  meaning the consumer accepts the head event.
REQ-008 evt_valid  output  1  meaning a queued event is presented.
REQ-009 evt_code  output  2  meaning the event type: 00 OVF, 01 UNF, 10 STEP_ERR; 11 is never driven.
REQ-010 evt_stamp  output  STAMP_W  meaning the cycle timestamp of the event.
REQ-011 ovf_cnt, unf_cnt, err_cnt, drop_cnt  output  8 each  meaning saturating statistics counters.

Function
REQ-012 The block SHALL implement a 2-state FSM, INIT and TRACK.
- INIT at posedge with rst=1: load prev_count=count and prev_updo=updo, then go to TRACK.
- No event is checked in INIT.
REQ-013 In TRACK, at each posedge, expected SHALL be prev_count+1 if prev_updo=1, else prev_count-1, computed modulo 16.
REQ-014 In TRACK, detection SHALL be as follows.
- count≠expected: STEP_ERR.
- Otherwise, prev_updo=1 and prev_count=15 with count=0: OVF.
- Otherwise, prev_updo=0 and prev_count=0 with count=15: UNF.
- Otherwise: no event.
REQ-015 In TRACK, prev_count and prev_updo SHALL reload from the inputs every cycle, so resync after STEP_ERR is automatic.
REQ-016 stamp SHALL be a free-running STAMP_W counter that increments every non-reset cycle and wraps to 0.
- Each event records the stamp value present at the detecting edge.
REQ-017 Each detected event SHALL be pushed into the FIFO at the detecting edge.
- evt_valid is high in the following cycle if the FIFO was empty.
- Latency from detecting edge to valid is 1 cycle; there is no combinational bypass.
REQ-018 Handshake: the head entry SHALL pop at a posedge where evt_valid=1 and evt_ready=1.
- evt_code and evt_stamp stay stable while evt_valid=1 and evt_ready=0.
REQ-019 When the FIFO is full, the push decision SHALL use the occupancy after a same-edge pop.
- With a pop at that edge, the new event is accepted.
- Without a pop, the event is discarded and drop_cnt increments.
REQ-020 A push to an empty FIFO SHALL NOT produce evt_valid in the same cycle; the queue is never bypassed.
REQ-021 ovf_cnt, unf_cnt and err_cnt SHALL increment on detection, independent of FIFO acceptance.
- All four statistics counters saturate at 255 and never wrap.
REQ-022 The FIFO SHALL preserve detection order, with the oldest entry at the head.

Reset
REQ-023 At a posedge with rst=0, the block SHALL clear all of the following.
- FSM returns to INIT.
- stamp, FIFO pointers and occupancy go to 0.
- All statistics counters go to 0.
- evt_valid goes to 0; evt_code and evt_stamp go to 0.
REQ-024 A reset asserted mid-operation SHALL discard all queued events.
- No event is checked on the first sample after reset release, because the FSM passes through INIT.
REQ-025 There SHALL be no asynchronous reset path; a rst glitch between edges has no effect.

Verification
REQ-026 Scenario 1: up-count from 13 for 4 cycles, evt_ready=1 -> one OVF event with the stamp of the 15->0 edge; ovf_cnt=1; no other events.
REQ-027 Scenario 2: down-count from 1 to 14 -> one UNF event; unf_cnt=1; evt_valid high exactly 1 cycle.
REQ-028 Scenario 3: count jumps 5->9 with updo=1 -> STEP_ERR, err_cnt=1; a following 9->10 produces no event.
REQ-029 Scenario 4: evt_ready=0, FIFO_DEPTH=4, six wraps -> 4 events held in order with stable head; drop_cnt=2.
- Then evt_ready=1 -> 4 pops in order and evt_valid falls.
REQ-030 Scenario 5: FIFO full, with a pop and a new wrap on the same edge -> the event is accepted, occupancy stays 4, drop_cnt is unchanged.
REQ-031 Scenario 6: rst=0 for 1 cycle while 3 events are queued -> evt_valid=0 next cycle and all counters 0.
- A 15->0 step on the first cycle after release produces no event.
